// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : Parametrised VGA raster timing generator with a registered,
//               blanked RGB output stage one enabled cycle behind the counters.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int H_ACTIVE  = 1280,
    parameter int H_FRONT   = 64,
    parameter int H_SYNC    = 136,
    parameter int H_BACK    = 200,
    parameter int V_ACTIVE  = 800,
    parameter int V_FRONT   = 1,
    parameter int V_SYNC    = 3,
    parameter int V_BACK    = 24,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b1,
    parameter int COLOR_W   = 4,
    localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK,
    localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK,
    localparam int CNT_W    = $clog2((H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pix_en,
    output logic [CNT_W-1:0]   pixel_x,
    output logic [CNT_W-1:0]   pixel_y,
    output logic               pixel_req,
    input  logic [COLOR_W-1:0] in_red,
    input  logic [COLOR_W-1:0] in_green,
    input  logic [COLOR_W-1:0] in_blue,
    output logic               hsync,
    output logic               vsync,
    output logic               de,
    output logic [COLOR_W-1:0] o_red,
    output logic [COLOR_W-1:0] o_green,
    output logic [COLOR_W-1:0] o_blue,
    output logic               frame_start,
    output logic               line_start
);

    if (H_ACTIVE < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
        V_ACTIVE < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1 ||
        COLOR_W < 1) begin : g_bad_params
        $error("vga_timing_gen: timing parameters must be nonzero and COLOR_W >= 1");
    end

    localparam logic [CNT_W-1:0] C_H_LAST  = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] C_V_LAST  = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] C_H_ACT   = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] C_V_ACT   = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] C_HS_BEG  = CNT_W'(H_ACTIVE + H_FRONT);
    localparam logic [CNT_W-1:0] C_HS_END  = CNT_W'(H_ACTIVE + H_FRONT + H_SYNC - 1);
    localparam logic [CNT_W-1:0] C_VS_BEG  = CNT_W'(V_ACTIVE + V_FRONT);
    localparam logic [CNT_W-1:0] C_VS_END  = CNT_W'(V_ACTIVE + V_FRONT + V_SYNC - 1);

    logic [CNT_W-1:0]   r_h;
    logic [CNT_W-1:0]   r_v;
    logic               r_hsync;
    logic               r_vsync;
    logic               r_de;
    logic [COLOR_W-1:0] r_red;
    logic [COLOR_W-1:0] r_green;
    logic [COLOR_W-1:0] r_blue;
    logic               r_frame_start;
    logic               r_line_start;

    logic w_h_wrap;
    logic w_v_wrap;
    logic w_hs_act;
    logic w_vs_act;
    logic w_req;

    assign w_h_wrap = (r_h == C_H_LAST);
    assign w_v_wrap = (r_v == C_V_LAST);
    assign w_hs_act = (r_h >= C_HS_BEG) && (r_h <= C_HS_END);
    // vsync depends on the line counter only, so it switches at h=0 of a line
    assign w_vs_act = (r_v >= C_VS_BEG) && (r_v <= C_VS_END);
    assign w_req    = (r_h < C_H_ACT) && (r_v < C_V_ACT);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_h           <= '0;
            r_v           <= '0;
            r_hsync       <= ~HSYNC_POL;
            r_vsync       <= ~VSYNC_POL;
            r_de          <= 1'b0;
            r_red         <= '0;
            r_green       <= '0;
            r_blue        <= '0;
            r_frame_start <= 1'b0;
            r_line_start  <= 1'b0;
        end else if (pix_en) begin
            r_h <= w_h_wrap ? '0 : r_h + 1'b1;
            if (w_h_wrap) begin
                r_v <= w_v_wrap ? '0 : r_v + 1'b1;
            end
            r_hsync       <= w_hs_act ? HSYNC_POL : ~HSYNC_POL;
            r_vsync       <= w_vs_act ? VSYNC_POL : ~VSYNC_POL;
            r_de          <= w_req;
            r_red         <= w_req ? in_red   : '0;
            r_green       <= w_req ? in_green : '0;
            r_blue        <= w_req ? in_blue  : '0;
            r_frame_start <= (r_h == '0) && (r_v == '0);
            r_line_start  <= (r_h == '0);
        end
    end

    assign pixel_x     = r_h;
    assign pixel_y     = r_v;
    assign pixel_req   = w_req;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign de          = r_de;
    assign o_red       = r_red;
    assign o_green     = r_green;
    assign o_blue      = r_blue;
    assign frame_start = r_frame_start;
    assign line_start  = r_line_start;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_timing_gen
// Description : Scoreboard bench for vga_timing_gen on a 14x8 raster.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    localparam int H_ACT = 8, H_FP = 2, H_SW = 3, H_BP = 1;
    localparam int V_ACT = 4, V_FP = 1, V_SW = 2, V_BP = 1;
    localparam int H_TOT = H_ACT + H_FP + H_SW + H_BP;
    localparam int V_TOT = V_ACT + V_FP + V_SW + V_BP;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       de;
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
        logic       fs;
        logic       ls;
    } out_t;

    typedef struct {
        out_t o;
        int   h;
        int   v;
    } sb_t;

    logic       clk;
    logic       reset;
    logic       pix_en;
    logic [3:0] pixel_x;
    logic [3:0] pixel_y;
    logic       pixel_req;
    logic [3:0] in_red, in_green, in_blue;
    logic       hsync, vsync, de;
    logic [3:0] o_red, o_green, o_blue;
    logic       frame_start, line_start;

    vga_timing_gen #(
        .H_ACTIVE(H_ACT), .H_FRONT(H_FP), .H_SYNC(H_SW), .H_BACK(H_BP),
        .V_ACTIVE(V_ACT), .V_FRONT(V_FP), .V_SYNC(V_SW), .V_BACK(V_BP),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b1), .COLOR_W(4)
    ) dut (
        .clk(clk), .reset(reset), .pix_en(pix_en),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_req(pixel_req),
        .in_red(in_red), .in_green(in_green), .in_blue(in_blue),
        .hsync(hsync), .vsync(vsync), .de(de),
        .o_red(o_red), .o_green(o_green), .o_blue(o_blue),
        .frame_start(frame_start), .line_start(line_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_tot = 0;
    int   n_bad = 0;
    sb_t  sbq[$];
    sb_t  cur;
    int   mh, mv;
    bit   rand_col;
    // statistics over enabled output cycles
    int   ecyc, last_ls, ls_per, last_fs, fs_per;
    int   hs_low, hs_hmin, hs_hmax, de_cnt, vs_cnt, vs_vmin, vs_vmax;
    int   prev_y;
    bit   wrap_seen;

    function automatic out_t model(int h, int v, logic [3:0] r, logic [3:0] g, logic [3:0] b);
        out_t o;
        o.hs = !(h >= H_ACT + H_FP && h < H_ACT + H_FP + H_SW);
        o.vs = (v >= V_ACT + V_FP && v < V_ACT + V_FP + V_SW);
        o.de = (h < H_ACT) && (v < V_ACT);
        o.r  = o.de ? r : 4'h0;
        o.g  = o.de ? g : 4'h0;
        o.b  = o.de ? b : 4'h0;
        o.fs = (h == 0) && (v == 0);
        o.ls = (h == 0);
        return o;
    endfunction

    task automatic clear_stats();
        hs_low = 0; hs_hmin = 99; hs_hmax = -1; de_cnt = 0;
        vs_cnt = 0; vs_vmin = 99; vs_vmax = -1; wrap_seen = 0;
    endtask

    task automatic step(input logic en);
        sb_t        e;
        out_t       act;
        logic [3:0] x;
        @(negedge clk);
        reset  = 1'b0;
        pix_en = en;
        x = 4'(mh);
        if (rand_col) begin
            in_red   = 4'($urandom_range(1, 15));
            in_green = 4'($urandom_range(1, 15));
            in_blue  = 4'($urandom_range(1, 15));
        end else begin
            in_red   = x;
            in_green = x;
            in_blue  = ~x;
        end
        #1;
        if (prev_y == V_TOT - 1 && pixel_y == 4'd0) wrap_seen = 1;
        prev_y = int'(pixel_y);
        n_tot++;
        if (pixel_x !== 4'(mh) || pixel_y !== 4'(mv) || pixel_req !== ((mh < H_ACT) && (mv < V_ACT))) begin
            n_bad++;
            $display("FAIL coords got x=%0d y=%0d req=%b want x=%0d y=%0d", pixel_x, pixel_y, pixel_req, mh, mv);
        end
        if (en) begin
            e.o = model(mh, mv, in_red, in_green, in_blue);
            e.h = mh;
            e.v = mv;
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
        if (en) begin
            cur = sbq.pop_front();
            if (mh == H_TOT - 1) begin
                mh = 0;
                mv = (mv == V_TOT - 1) ? 0 : mv + 1;
            end else begin
                mh = mh + 1;
            end
        end
        act = {hsync, vsync, de, o_red, o_green, o_blue, frame_start, line_start};
        n_tot++;
        if (act !== cur.o) begin
            n_bad++;
            $display("FAIL outstage h=%0d v=%0d en=%b got=%h want=%h", cur.h, cur.v, en, act, cur.o);
        end
        if (en) begin
            ecyc++;
            if (line_start) begin
                if (last_ls >= 0) ls_per = ecyc - last_ls;
                last_ls = ecyc;
            end
            if (frame_start) begin
                if (last_fs >= 0) fs_per = ecyc - last_fs;
                last_fs = ecyc;
            end
            if (!hsync) begin
                hs_low++;
                if (cur.h < hs_hmin) hs_hmin = cur.h;
                if (cur.h > hs_hmax) hs_hmax = cur.h;
            end
            if (vsync) begin
                vs_cnt++;
                if (cur.v < vs_vmin) vs_vmin = cur.v;
                if (cur.v > vs_vmax) vs_vmax = cur.v;
            end
            if (de) de_cnt++;
        end
    endtask

    // Holds reset (with pix_en=1 to exercise priority) for n edges; release is in step.
    task automatic do_reset(input int n);
        out_t rv;
        out_t act;
        rv = {1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0};
        @(negedge clk);
        reset = 1'b1;
        pix_en = 1'b1;
        in_red = 4'hF; in_green = 4'hF; in_blue = 4'hF;
        repeat (n) begin
            @(posedge clk);
            #1;
            act = {hsync, vsync, de, o_red, o_green, o_blue, frame_start, line_start};
            n_tot++;
            if (act !== rv || pixel_x !== 4'd0 || pixel_y !== 4'd0) begin
                n_bad++;
                $display("FAIL reset_state got=%h x=%0d y=%0d want=%h x=0 y=0", act, pixel_x, pixel_y, rv);
            end
        end
        mh = 0; mv = 0;
        sbq.delete();
        cur.o = rv; cur.h = 0; cur.v = 0;
        last_ls = -1; last_fs = -1; ls_per = 0; fs_per = 0; ecyc = 0;
    endtask

    task automatic test_reset();
        do_reset(3);
        step(1'b1);
        n_tot++;
        if ({frame_start, line_start, de} !== 3'b111) begin
            n_bad++;
            $display("FAIL first_after_reset got fs/ls/de=%b want 111", {frame_start, line_start, de});
        end
    endtask

    task automatic test_one_line();
        clear_stats();
        repeat (H_TOT) step(1'b1);
        n_tot++;
        if (hs_low != 3 || hs_hmin != 10 || hs_hmax != 12) begin
            n_bad++;
            $display("FAIL hsync_width got=%0d h=%0d..%0d want=3 h=10..12", hs_low, hs_hmin, hs_hmax);
        end
        n_tot++;
        if (de_cnt != 8) begin
            n_bad++;
            $display("FAIL de_per_line got=%0d want=8", de_cnt);
        end
        n_tot++;
        if (ls_per != 14) begin
            n_bad++;
            $display("FAIL line_period got=%0d want=14", ls_per);
        end
    endtask

    task automatic test_frames();
        for (int f = 0; f < 2; f++) begin
            clear_stats();
            repeat (H_TOT * V_TOT) step(1'b1);
            n_tot++;
            if (vs_cnt != 28 || vs_vmin != 5 || vs_vmax != 6) begin
                n_bad++;
                $display("FAIL vsync_width got=%0d v=%0d..%0d want=28 v=5..6", vs_cnt, vs_vmin, vs_vmax);
            end
            n_tot++;
            if (fs_per != 112) begin
                n_bad++;
                $display("FAIL frame_period got=%0d want=112", fs_per);
            end
            n_tot++;
            if (!wrap_seen) begin
                n_bad++;
                $display("FAIL y_wrap got=0 want=1");
            end
        end
    endtask

    task automatic test_color();
        rand_col = 1;
        clear_stats();
        repeat (H_TOT * V_TOT) step(1'b1);
        rand_col = 0;
        n_tot++;
        if (de_cnt != H_ACT * V_ACT) begin
            n_bad++;
            $display("FAIL de_per_frame got=%0d want=%0d", de_cnt, H_ACT * V_ACT);
        end
    endtask

    task automatic test_pix_en();
        fs_per = 0;
        clear_stats();
        for (int i = 0; i < 4 * H_TOT * V_TOT; i++) begin
            step((i % 4 == 0) || (i % 4 == 3));
        end
        n_tot++;
        if (fs_per != 112) begin
            n_bad++;
            $display("FAIL frame_period_gated got=%0d want=112", fs_per);
        end
        n_tot++;
        if (hs_low != 48 || vs_cnt != 56) begin
            n_bad++;
            $display("FAIL sync_gated got hs=%0d vs=%0d want hs=48 vs=56", hs_low, vs_cnt);
        end
    endtask

    task automatic test_mid_reset();
        int guard;
        guard = 0;
        while (!(mh == 11 && mv == 5) && guard < 300) begin
            step(1'b1);
            guard++;
        end
        n_tot++;
        if (!(mh == 11 && mv == 5) || hsync !== 1'b0 || vsync !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_reset_setup got h=%0d v=%0d hs=%b vs=%b want h=11 v=5 hs=0 vs=1",
                     mh, mv, hsync, vsync);
        end
        do_reset(1);
        step(1'b1);
        n_tot++;
        if ({frame_start, line_start, de, hsync, vsync} !== 5'b11110) begin
            n_bad++;
            $display("FAIL restart got fs/ls/de/hs/vs=%b want 11110",
                     {frame_start, line_start, de, hsync, vsync});
        end
        repeat (H_TOT) step(1'b1);
    endtask

    initial begin
        reset = 1'b1; pix_en = 1'b0;
        in_red = '0; in_green = '0; in_blue = '0;
        rand_col = 0; prev_y = 0; mh = 0; mv = 0;
        test_reset();
        test_one_line();
        test_frames();
        test_color();
        test_pix_en();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
